prog_loader: RTL

//  Boot-time program loader, the write-side counterpart of the memory dump path: accepts a byte stream
//  (valid/ready), packs bytes into 32-bit words and writes them into instruction/data RAM at word index 0..N-1.

---
 rtl/prog_loader_pkg.sv | 24 ++
 rtl/prog_loader_if.sv | 32 +++
 rtl/prog_loader_byte_packer.sv | 35 +++
 rtl/prog_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: stream framing constants,
// the loader FSM state encoding and the word-packing geometry.
package prog_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    // The loader takes bytes in every state except the two terminal ones.
    function automatic logic accepts_bytes(input state_t s);
        return (s != DONE) && (s != ERR);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and RAM write port of the program loader, bundled as one interface.
// master = host side (byte source / RAM owner), slave = loader side.
interface prog_loader_if #(
    parameter int ADDR_W = 9
) ();

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs an LSB-first byte stream into 32-bit words; word_valid flags the byte that
// completes a word, with the finished word presented combinationally on the same cycle.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    localparam int LOW_W = WORD_W - 8;

    logic [1:0]       byte_idx;
    logic [LOW_W-1:0] low_bytes;

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx  <= '0;
            low_bytes <= '0;
        end else if (byte_en) begin
            byte_idx  <= byte_idx + 2'd1;
            low_bytes <= {byte_in, low_bytes[LOW_W-1:8]};
        end
    end

    // After three bytes low_bytes holds {b2,b1,b0}; the fourth byte tops off the word.
    assign word_valid = byte_en && (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign word       = {byte_in, low_bytes};

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a counted, checksummed byte image, writes it to RAM
// word by word, and releases the CPU from reset only once the whole image has verified.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 512
) (
    input  logic         clock,
    input  logic         reset,
    prog_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         done,
    output logic         error
);

    localparam logic [CNT_W:0] MAX_LIMIT = (CNT_W + 1)'(MAX_WORDS);

    state_t             state;
    logic [CNT_W-1:0]   word_total;
    logic [CNT_W-1:0]   word_idx;
    logic [7:0]         xor_acc;

    logic               transfer;
    logic               pack_en;
    logic [WORD_W-1:0]  packed_word;
    logic               word_valid;
    logic [CNT_W-1:0]   hdr_total;

    assign transfer  = bus.in_valid && bus.in_ready;
    assign pack_en   = transfer && (state == DATA);
    assign hdr_total = {bus.in_data, word_total[7:0]};

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .byte_en    (pack_en),
        .byte_in    (bus.in_data),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= HDR_LO;
            word_total    <= '0;
            word_idx      <= '0;
            xor_acc       <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_reset     <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            // in_ready is registered from the current state; terminal entries clear it below.
            bus.in_ready <= accepts_bytes(state);
            bus.mem_we   <= 1'b0;

            if (transfer) begin
                xor_acc <= xor_acc ^ bus.in_data;

                unique case (state)
                    HDR_LO: begin
                        word_total[7:0] <= bus.in_data;
                        state           <= HDR_HI;
                    end

                    HDR_HI: begin
                        word_total <= hdr_total;
                        word_idx   <= '0;
                        // Size is checked before any data byte, so an oversize image never writes RAM.
                        if ({1'b0, hdr_total} > MAX_LIMIT) begin
                            state        <= ERR;
                            error        <= 1'b1;
                            bus.in_ready <= 1'b0;
                        end else if (hdr_total == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end

                    DATA: begin
                        if (word_valid) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= word_idx[ADDR_W-1:0];
                            bus.mem_wdata <= packed_word;
                            word_idx      <= word_idx + 16'd1;
                            if (word_idx == word_total - 16'd1) begin
                                state <= CSUM;
                            end
                        end
                    end

                    CSUM: begin
                        bus.in_ready <= 1'b0;
                        if ((xor_acc ^ bus.in_data) == 8'h00) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
